// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, board clock constants and the
// baud divisor helper reused by both the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } uart_state_t;

    localparam int CLK_FREQ_HZ  = 100_000_000;
    localparam int BAUD_DEFAULT = 115200;

    // Rounded to the nearest whole cycle so the bit-time error stays below half a clock.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-rate clock-enable: a free-running divider that fires a one-cycle tick
// every CLKS_PER_BIT cycles and restarts its bit period on a synchronous clear.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic internal_clk_fgpa,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
    end

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge internal_clk_fgpa or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a word on a valid/ready handshake and shifts it out
// as start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_DEFAULT),
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 internal_clk_fgpa,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_serializer: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 accept;
    logic                 tick;

    assign accept = tx_valid && tx_ready;

    // Clearing on accept aligns every bit boundary of the frame to the accepting edge.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .internal_clk_fgpa(internal_clk_fgpa),
        .rst_n            (rst_n),
        .clear            (accept),
        .tick             (tick)
    );

    always_ff @(posedge internal_clk_fgpa or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            shift_reg <= '0;
            data_reg  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                // DONE behaves like IDLE for acceptance, allowing one-idle-cycle back-to-back frames.
                IDLE, DONE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        shift_reg <= tx_data;
                        data_reg  <= tx_data;
                        bit_cnt   <= '0;
                        stop_cnt  <= 1'b0;
                        state     <= START;
                        tx        <= 1'b0;
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state     <= DATA;
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= (^data_reg) ^ (PARITY_ODD != 0);
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            state    <= DONE;
                            tx       <= 1'b1;
                            tx_done  <= 1'b1;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations share one stimulus stream and
// are compared every cycle against a per-cycle waveform model built from frame rules.
module tb_uart_tx_serializer;

    localparam int NI = 4;
    localparam int CPB[NI]   = '{4, 4, 4, 2};
    localparam int DBITS[NI] = '{8, 8, 8, 5};
    localparam int PEN[NI]   = '{0, 1, 1, 0};
    localparam int PODD[NI]  = '{0, 0, 1, 0};
    localparam int SBITS[NI] = '{1, 1, 2, 1};

    logic       internal_clk_fgpa = 1'b0;
    logic       rst_n             = 1'b0;
    logic [7:0] tx_data           = '0;
    logic       tx_valid          = 1'b0;
    logic       tx_w[NI];
    logic       rdy_w[NI];
    logic       busy_w[NI];
    logic       done_w[NI];

    int n_checks = 0;
    int n_fail   = 0;
    int model_q[NI][$];
    int rdy_prev[NI] = '{default: 1};
    bit running = 1'b1;

    int seq_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int seq_81[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    int seq_55[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_8n1 (
        .internal_clk_fgpa(internal_clk_fgpa), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_8e1 (
        .internal_clk_fgpa(internal_clk_fgpa), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_8o2 (
        .internal_clk_fgpa(internal_clk_fgpa), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

    uart_tx_serializer #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_5n1 (
        .internal_clk_fgpa(internal_clk_fgpa), .rst_n(rst_n), .tx_data(tx_data[4:0]), .tx_valid(tx_valid),
        .tx_ready(rdy_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    always #5 internal_clk_fgpa = ~internal_clk_fgpa;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Expected line level for every cycle of a frame; the value 2 marks the DONE cycle.
    task automatic buildFrame(input int i, input int data);
        int par = 0;
        int bv;
        repeat (CPB[i]) model_q[i].push_back(0);
        for (int b = 0; b < DBITS[i]; b++) begin
            bv  = (data >> b) & 1;
            par = par ^ bv;
            repeat (CPB[i]) model_q[i].push_back(bv);
        end
        if (PEN[i] != 0) begin
            repeat (CPB[i]) model_q[i].push_back(par ^ PODD[i]);
        end
        repeat (SBITS[i] * CPB[i]) model_q[i].push_back(1);
        model_q[i].push_back(2);
    endtask

    task automatic modelCycle();
        for (int i = 0; i < NI; i++) begin
            int e_tx, e_rdy, e_busy, e_done, e;
            e_tx = 1; e_rdy = 1; e_busy = 0; e_done = 0;
            if (!rst_n) begin
                model_q[i].delete();
            end else begin
                if (rdy_prev[i] != 0 && tx_valid) begin
                    buildFrame(i, int'(tx_data));
                end
                if (model_q[i].size() != 0) begin
                    e = model_q[i].pop_front();
                    if (e == 2) begin
                        e_done = 1;
                    end else begin
                        e_tx = e; e_rdy = 0; e_busy = 1;
                    end
                end
            end
            rdy_prev[i] = e_rdy;
            checkOutput($sformatf("u%0d_tx", i), int'(tx_w[i]), e_tx);
            checkOutput($sformatf("u%0d_ready", i), int'(rdy_w[i]), e_rdy);
            checkOutput($sformatf("u%0d_busy", i), int'(busy_w[i]), e_busy);
            checkOutput($sformatf("u%0d_done", i), int'(done_w[i]), e_done);
        end
    endtask

    task automatic nextCycle();
        @(posedge internal_clk_fgpa);
        #1;
    endtask

    task automatic waitAllIdle();
        int n = 0;
        bit idle = 1'b0;
        while (!idle && n < 300) begin
            idle = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (!rdy_w[i] || busy_w[i]) idle = 1'b0;
            end
            if (!idle) begin
                nextCycle();
                n++;
            end
        end
        if (!idle) checkOutput("idle_timeout", 0, 1);
    endtask

    // Presents a word and returns sampled inside cycle 1 (the cycle after the accepting edge).
    task automatic applyStimulus(input logic [7:0] d);
        @(negedge internal_clk_fgpa);
        tx_data  = d;
        tx_valid = 1'b1;
        nextCycle();
    endtask

    task automatic sendFrame8n1(input logic [7:0] d, input int seq[10], input int pulse_at);
        applyStimulus(d);
        for (int c = 1; c <= 41; c++) begin
            checkOutput($sformatf("f%h_tx_c%0d", d, c), int'(tx_w[0]), (c <= 40) ? seq[(c - 1) / 4] : 1);
            checkOutput($sformatf("f%h_done_c%0d", d, c), int'(done_w[0]), int'(c == 41));
            checkOutput($sformatf("f%h_ready_c%0d", d, c), int'(rdy_w[0]), int'(c == 41));
            @(negedge internal_clk_fgpa);
            tx_valid = (c == pulse_at);
            if (c == pulse_at) tx_data = 8'hC3;
            nextCycle();
        end
    endtask

    task automatic runTests();
        int pulses;

        // Reset held for five cycles, then idle line with no request.
        repeat (5) nextCycle();
        checkOutput("rst_tx", int'(tx_w[0]), 1);
        checkOutput("rst_ready", int'(rdy_w[0]), 1);
        checkOutput("rst_busy", int'(busy_w[0]), 0);
        @(negedge internal_clk_fgpa);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            checkOutput("idle_tx", int'(tx_w[0]), 1);
            checkOutput("idle_done", int'(done_w[0]), 0);
        end

        $display("[TB] 8N1 frame 0xA5");
        sendFrame8n1(8'hA5, seq_a5, 0);

        $display("[TB] parity and two stop bits, 0x07");
        waitAllIdle();
        applyStimulus(8'h07);
        for (int c = 1; c <= 50; c++) begin
            if (c >= 37 && c <= 40) begin
                checkOutput("even_parity_bit", int'(tx_w[1]), 1);
                checkOutput("odd_parity_bit", int'(tx_w[2]), 0);
            end
            if (c >= 41 && c <= 48) checkOutput("stop2_level", int'(tx_w[2]), 1);
            if (c == 45) checkOutput("e1_done_c45", int'(done_w[1]), 1);
            if (c == 48) checkOutput("o2_busy_c48", int'(busy_w[2]), 1);
            if (c == 49) checkOutput("o2_done_c49", int'(done_w[2]), 1);
            @(negedge internal_clk_fgpa);
            tx_valid = 1'b0;
            nextCycle();
        end

        $display("[TB] back-to-back 0x00 then 0xFF");
        waitAllIdle();
        applyStimulus(8'h00);
        pulses = 0;
        for (int c = 1; c <= 90; c++) begin
            if (done_w[0]) pulses++;
            if (c == 1)  checkOutput("b2b_first_start", int'(tx_w[0]), 0);
            if (c == 41) checkOutput("b2b_gap_done", int'(done_w[0]), 1);
            if (c == 41) checkOutput("b2b_gap_tx", int'(tx_w[0]), 1);
            if (c == 42) checkOutput("b2b_second_start", int'(tx_w[0]), 0);
            if (c == 46) checkOutput("b2b_second_d0", int'(tx_w[0]), 1);
            @(negedge internal_clk_fgpa);
            if (c == 2) tx_data = 8'hFF;
            if (c == 42) tx_valid = 1'b0;
            nextCycle();
        end
        checkOutput("b2b_done_pulses", pulses, 2);

        $display("[TB] reset mid-frame 0x3C, then 0x81");
        waitAllIdle();
        applyStimulus(8'h3C);
        for (int c = 1; c < 15; c++) begin
            @(negedge internal_clk_fgpa);
            tx_valid = 1'b0;
            nextCycle();
        end
        checkOutput("abort_pre_busy", int'(busy_w[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_tx", int'(tx_w[0]), 1);
        checkOutput("abort_busy", int'(busy_w[0]), 0);
        checkOutput("abort_ready", int'(rdy_w[0]), 1);
        checkOutput("abort_done", int'(done_w[0]), 0);
        repeat (3) nextCycle();
        @(negedge internal_clk_fgpa);
        rst_n = 1'b1;
        for (int c = 0; c < 45; c++) begin
            nextCycle();
            if (done_w[0]) checkOutput("abort_no_done", 1, 0);
        end
        sendFrame8n1(8'h81, seq_81, 0);

        $display("[TB] request while busy is ignored");
        waitAllIdle();
        sendFrame8n1(8'h55, seq_55, 10);
        for (int c = 0; c < 10; c++) begin
            checkOutput("ignored_no_frame", int'(tx_w[0]), 1);
            nextCycle();
        end

        $display("[TB] randomized traffic");
        for (int it = 0; it < 60; it++) begin
            @(negedge internal_clk_fgpa);
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge internal_clk_fgpa);
            tx_valid = 1'b1;
            repeat ($urandom_range(1, 60)) @(negedge internal_clk_fgpa);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                @(negedge internal_clk_fgpa);
                rst_n = 1'b1;
            end
        end
        @(negedge internal_clk_fgpa);
        tx_valid = 1'b0;
        waitAllIdle();
        repeat (3) nextCycle();
    endtask

    initial begin
        fork
            begin
                while (running) begin
                    nextCycle();
                    modelCycle();
                end
            end
            begin
                runTests();
                running = 1'b0;
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit serializer that sits directly downstream of the board clock-divider stage. It takes parallel bytes over a valid/ready handshake and drives the serial TX line as frames: start bit, data bits LSB first, optional parity bit, then stop bits. Bit timing comes from a clock-enable tick derived from the 100 MHz board clock. It does not use a derived clock, so the block is fully synchronous to the single board clock.

Parameters:
CLKS_PER_BIT, 868, board-clock cycles per serial bit (100 MHz / 115200); must be >= 2, otherwise elaboration error
DATA_BITS, 8, data bits per frame (5..9)
PARITY_EN, 0, 1 = append a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
internal_clk_fgpa  in   1          board clock, 100 MHz; all logic on its rising edge
rst_n              in   1          reset, asynchronous and active-low
tx_data            in   DATA_BITS  byte to send; must be stable while tx_valid=1
tx_valid           in   1          upstream has data
tx_ready           out  1          block can accept data
tx                 out  1          serial line, idle high
tx_busy            out  1          high while a frame is in progress
tx_done            out  1          one-cycle pulse after the last stop bit

Behaviour:
- Reset (rst_n=0, asynchronous): tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0. A reset mid-frame aborts the frame immediately: tx returns high, no tx_done. Normal operation resumes on the first edge after release.
- Handshake: a transfer happens on the rising edge where tx_valid && tx_ready.
  - On that edge: tx_data is latched into the shift register, the baud counter is cleared, state goes to START, tx_ready goes to 0, tx_busy goes to 1.
  - tx_valid while tx_ready=0 is ignored; no queuing.
- Call the accepting edge cycle 0. tx is driven low from cycle 1.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- States and transitions:
  - IDLE: tx=1, tx_ready=1 → START on accept.
  - START: tx=0 → DATA after one bit time.
  - DATA: tx=shift[0], shifted right each bit; the bit counter counts 0..DATA_BITS-1 → PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of data bits (even), or its inverse (odd) → STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles → DONE.
  - DONE: one cycle with tx=1, tx_done=1, tx_ready=1, tx_busy=0 → IDLE. If tx_valid=1 in this cycle, the accept occurs at this edge (state → START), giving exactly one idle cycle between frames.
- Frame period, back-to-back: (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT + 1 cycles.
- Widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits; the tick fires at count CLKS_PER_BIT-1 and wraps to 0.
  - Bit counter is $clog2(DATA_BITS+1) bits.
  - The stop-bit counter counts ticks 0..STOP_BITS-1.
- tx is registered, with no combinational path from any input to tx.
- tx_done is never asserted without a preceding accepted transfer.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding: IDLE, START, DATA, PARITY, STOP, DONE;
  - CLK_FREQ_HZ=100_000_000 and BAUD_DEFAULT=115200;
  - a constant function computing CLKS_PER_BIT, for reuse by the future uart_rx.
- Sub-module uart_baud_tick(CLKS_PER_BIT), ports internal_clk_fgpa, rst_n, clear, tick. It is a counter with synchronous clear and a one-cycle tick. The same module will be reused by uart_rx.

Test Plan:
1. Hold rst_n=0 for 5 cycles, then release → tx=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; tx stays 1 while tx_valid=0.
2. CLKS_PER_BIT=4, 8N1; send 0xA5 → tx holds each bit value for 4 cycles in the sequence 0,1,0,1,0,0,1,0,1,1 over cycles 1..40; tx_done=1 and tx_ready=1 only in cycle 41.
3. PARITY_EN=1, PARITY_ODD=0; send 0x07 → parity bit 1; repeat with PARITY_ODD=1 → parity bit 0; STOP_BITS=2 → stop level held 8 cycles.
4. tx_valid held high with 0x00 then 0xFF, CLKS_PER_BIT=4, 8N1 → second start bit begins exactly 41 cycles after the first; two tx_done pulses total.
5. Assert rst_n=0 at cycle 15 of a 0x3C frame → tx=1 immediately (asynchronous), no tx_done; after release, send 0x81 → correct frame.
6. Accept 0x55, then pulse tx_valid with 0xC3 at cycle 10 → 0xC3 ignored; exactly one frame (0x55) on tx; tx_ready stays 0 until the DONE cycle.
